// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types and defaults for the GCD engine.
//   gcd_state_e    : controller states, fetch A, fetch B, compute, present
//   DATA_WIDTH_DEF : default operand/result width (matches the operand FIFO)
package gcd_pkg;

    typedef enum logic [2:0] {
        REQ_A,
        CAP_A,
        REQ_B,
        CAP_B,
        CALC,
        DONE
    } gcd_state_e;

    localparam int DATA_WIDTH_DEF = 4;

endpackage

// File: rtl/gcd_datapath.sv
// gcd_datapath: operand registers and the subtractive Euclid step.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   i_load_a      : capture i_data into A
//   i_load_b      : capture i_data into B
//   i_step        : perform one Euclid step (or finish if terminal)
//   i_data        : operand word from the FIFO read port
//   o_done        : current A/B is terminal; the step this cycle writes the result
//   o_result      : last computed GCD, held until the next one finishes
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  i_load_a,
    input  logic                  i_load_b,
    input  logic                  i_step,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result
);

    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_result;

    logic                  w_a_zero;
    logic                  w_b_zero;
    logic                  w_equal;
    logic                  w_a_gt_b;
    logic [DATA_WIDTH-1:0] w_final;

    assign w_a_zero = (r_a == '0);
    assign w_b_zero = (r_b == '0);
    assign w_equal  = (r_a == r_b);
    assign w_a_gt_b = (r_a > r_b);

    // A zero operand makes the other one the answer; equal operands are the answer.
    assign o_done  = w_b_zero | w_a_zero | w_equal;
    assign w_final = w_b_zero ? r_a : (w_a_zero ? r_b : r_a);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else begin
            if (i_load_a) begin
                r_a <= i_data;
            end
            if (i_load_b) begin
                r_b <= i_data;
            end
            if (i_step) begin
                if (o_done) begin
                    r_result <= w_final;
                end else if (w_a_gt_b) begin
                    r_a <= r_a - r_b;
                end else begin
                    r_b <= r_b - r_a;
                end
            end
        end
    end

    assign o_result = r_result;

endmodule

// File: rtl/gcd_engine.sv
// gcd_engine: pops operand pairs (A then B) from a FIFO, computes GCD by
// repeated subtraction and offers the result on a valid/ready port.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   fifo_empty_i   : FIFO empty flag
//   fifo_rd_en_o   : FIFO pop request
//   fifo_data_i    : FIFO read data, valid the cycle after a pop
//   result_o       : GCD result, held after the handshake
//   result_valid_o : result available
//   result_ready_i : downstream accepts result
//   busy_o         : engine is not idle waiting for operand A
//
// state | meaning
// REQ_A | pop operand A as soon as the FIFO is non-empty
// CAP_A | FIFO data for A arrives, load A
// REQ_B | pop operand B as soon as the FIFO is non-empty
// CAP_B | FIFO data for B arrives, load B
// CALC  | one subtraction step per cycle until terminal
// DONE  | present result, wait for result_ready_i
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic                  busy_o
);

    gcd_state_e r_state;
    gcd_state_e w_state_next;

    logic w_pop;
    logic w_load_a;
    logic w_load_b;
    logic w_step;
    logic w_valid;
    logic w_done;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= REQ_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_load_a     = 1'b0;
        w_load_b     = 1'b0;
        w_step       = 1'b0;
        w_valid      = 1'b0;
        case (r_state)
            REQ_A: begin
                if (!fifo_empty_i) begin
                    w_pop        = 1'b1;
                    w_state_next = CAP_A;
                end
            end
            CAP_A: begin
                w_load_a     = 1'b1;
                w_state_next = REQ_B;
            end
            REQ_B: begin
                if (!fifo_empty_i) begin
                    w_pop        = 1'b1;
                    w_state_next = CAP_B;
                end
            end
            CAP_B: begin
                w_load_b     = 1'b1;
                w_state_next = CALC;
            end
            CALC: begin
                w_step = 1'b1;
                if (w_done) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_valid = 1'b1;
                if (result_ready_i) begin
                    w_state_next = REQ_A;
                end
            end
            default: begin
                w_state_next = REQ_A;
            end
        endcase
    end

    // The state register sits at REQ_A throughout reset, so the pop request
    // must be masked by the reset itself or the FIFO would drain during reset.
    assign fifo_rd_en_o   = w_pop & rst_ni;
    assign result_valid_o = w_valid;
    assign busy_o         = (r_state != REQ_A);

    gcd_datapath #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_datapath (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .i_load_a (w_load_a),
        .i_load_b (w_load_b),
        .i_step   (w_step),
        .i_data   (fifo_data_i),
        .o_done   (w_done),
        .o_result (result_o)
    );

endmodule

// File: tb/tb_gcd_engine.sv
module tb_gcd_engine;

    localparam int W = 4;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         fifo_empty_i;
    logic         fifo_rd_en_o;
    logic [W-1:0] fifo_data = '0;
    logic [W-1:0] result_o;
    logic         result_valid_o;
    logic         result_ready_i = 1'b0;
    logic         busy_o;

    logic         force_empty = 1'b0;
    int           pushed_cnt = 0;
    int           popped_cnt = 0;
    logic [W-1:0] fq[$];

    int           cyc = 0;
    int           pops = 0;
    int           viol = 0;
    int           a_pop_edge = 0;
    int           last_lat = -1;
    logic         prev_valid = 1'b0;
    int           rec[$];
    int           expq[$];

    int           checks = 0;
    int           errors = 0;

    always #5 clk_i = ~clk_i;

    gcd_engine #(.DATA_WIDTH(W)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .fifo_empty_i   (fifo_empty_i),
        .fifo_rd_en_o   (fifo_rd_en_o),
        .fifo_data_i    (fifo_data),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .busy_o         (busy_o)
    );

    assign fifo_empty_i = (pushed_cnt == popped_cnt) || force_empty;

    // FIFO model: one-cycle read latency.
    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (fifo_rd_en_o && fq.size() > 0) begin
            fifo_data  <= fq.pop_front();
            popped_cnt <= popped_cnt + 1;
        end
    end

    // Monitor: inputs settle at the falling edge, so what is seen here is what
    // the next rising edge acts on.
    always @(negedge clk_i) begin
        #1;
        if (fifo_rd_en_o) begin
            if (fifo_empty_i) viol++;
            if (pops % 2 == 0) a_pop_edge = cyc + 1;
            pops++;
        end
        if (result_valid_o && !prev_valid) last_lat = cyc - a_pop_edge;
        prev_valid = result_valid_o;
        if (result_valid_o && result_ready_i) rec.push_back(int'(result_o));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int v);
        fq.push_back(W'(v));
        pushed_cnt++;
    endtask

    task automatic wait_results(input string tag, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (rec.size() >= n) break;
        end
        check(tag, rec.size(), n);
    endtask

    function automatic int ref_gcd(input int a, input int b);
        int x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    initial begin
        int p0;
        int base;
        int got;
        int a, b;

        // Reset with data already waiting: no pop may happen.
        push(12); push(8);
        repeat (3) @(negedge clk_i);
        #2;
        check("rst_rd_en", fifo_rd_en_o, 0);
        check("rst_valid", result_valid_o, 0);
        check("rst_result", result_o, 0);
        check("rst_busy", busy_o, 0);

        // 1: single pair (12,8), S=2
        @(negedge clk_i);
        rst_ni = 1'b1;
        result_ready_i = 1'b1;
        wait_results("t1_count", 1, 200);
        check("t1_result", rec[0], 4);
        check("t1_latency", last_lat, 6);
        check("t1_pops", pops, 2);

        // 2: back-to-back pairs
        push(9); push(6); push(7); push(0); push(0); push(0); push(15); push(1);
        wait_results("t2_count", 5, 300);
        check("t2_r0", rec[1], 3);
        check("t2_r1", rec[2], 7);
        check("t2_r2", rec[3], 0);
        check("t2_r3", rec[4], 1);
        check("t2_pops", pops, 10);
        check("t2_latency_15_1", last_lat, 18);

        // 3: B arrives late
        push(5);
        repeat (5) @(negedge clk_i);
        #2;
        check("t3_pops_stalled", pops, 11);
        check("t3_rd_en_empty", fifo_rd_en_o, 0);
        check("t3_busy", busy_o, 1);
        @(negedge clk_i);
        push(10);
        wait_results("t3_count", 6, 200);
        check("t3_result", rec[5], 5);

        // 4: downstream stalls in DONE
        @(negedge clk_i);
        result_ready_i = 1'b0;
        push(8); push(12); push(9); push(3);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            #2;
            if (result_valid_o) break;
        end
        check("t4_valid_seen", result_valid_o, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            #2;
            check("t4_hold_result", result_o, 4);
            check("t4_hold_valid", result_valid_o, 1);
            check("t4_hold_rd_en", fifo_rd_en_o, 0);
        end
        check("t4_pops", pops, 14);
        @(negedge clk_i);
        result_ready_i = 1'b1;
        wait_results("t4_count", 8, 200);
        check("t4_r0", rec[6], 4);
        check("t4_r1", rec[7], 3);

        // 5: reset pulse during CALC of (15,1)
        p0 = pops;
        @(negedge clk_i);
        push(15); push(1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            #2;
            if (pops >= p0 + 2) break;
        end
        check("t5_pops_before", pops, p0 + 2);
        repeat (4) @(negedge clk_i);
        #2;
        check("t5_busy_calc", busy_o, 1);
        check("t5_result_before", result_o, 3);
        @(negedge clk_i);
        rst_ni = 1'b0;
        push(6); push(4);
        #2;
        check("t5_rst_valid", result_valid_o, 0);
        check("t5_rst_result", result_o, 0);
        check("t5_rst_busy", busy_o, 0);
        check("t5_rst_rd_en", fifo_rd_en_o, 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        wait_results("t5_count", 9, 200);
        check("t5_result", rec[8], 2);
        check("t5_pops", pops, 20);

        // 6: random operands with random empty/ready
        base = rec.size();
        for (int i = 0; i < 1000; i++) begin
            a = $urandom_range(0, 15);
            b = $urandom_range(0, 15);
            push(a); push(b);
            expq.push_back(ref_gcd(a, b));
        end
        for (int i = 0; i < 60000; i++) begin
            @(negedge clk_i);
            if (rec.size() >= base + 1000) break;
            force_empty = ($urandom_range(0, 9) < 3);
            result_ready_i = ($urandom_range(0, 9) < 6);
        end
        force_empty = 1'b0;
        result_ready_i = 1'b1;
        check("t6_count", rec.size(), base + 1000);
        got = rec.size() - base;
        if (got > 1000) got = 1000;
        for (int i = 0; i < got; i++) begin
            check($sformatf("t6_pair%0d", i), rec[base + i], expq[i]);
        end
        check("t6_pops", pops, 2020);
        check("no_pop_while_empty", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
